// File: rtl/sdram_burst_sequencer_if.sv
// SDRAM command-core handshake bundle for the burst sequencer.
// master = sequencer side, slave = SDRAM command core side.
interface sdram_burst_sequencer_if #(
   parameter int AW = 22
) ();
   logic          sd_wr_req;
   logic [AW-1:0] sd_wr_addr;
   logic          sd_wr_ack;
   logic          sd_wr_data_req;
   logic          sd_wr_done;
   logic          sd_rd_req;
   logic [AW-1:0] sd_rd_addr;
   logic          sd_rd_ack;
   logic          sd_rd_data_vld;
   logic          sd_rd_done;

   modport master (
      output sd_wr_req,
      output sd_wr_addr,
      input  sd_wr_ack,
      input  sd_wr_data_req,
      input  sd_wr_done,
      output sd_rd_req,
      output sd_rd_addr,
      input  sd_rd_ack,
      input  sd_rd_data_vld,
      input  sd_rd_done
   );

   modport slave (
      input  sd_wr_req,
      input  sd_wr_addr,
      output sd_wr_ack,
      output sd_wr_data_req,
      output sd_wr_done,
      input  sd_rd_req,
      input  sd_rd_addr,
      output sd_rd_ack,
      output sd_rd_data_vld,
      output sd_rd_done
   );
endinterface

// File: rtl/sdram_burst_sequencer.sv
// Arbitrates FIFO write/read triggers into single SDRAM bursts and
// keeps frame-buffer addresses. Optional macro: FRAME_PINGPONG_EN.
module sdram_burst_sequencer #(
   parameter int AW          = 22,
   parameter int BURST_LEN   = 256,
   parameter int FRAME_WORDS = 307200
) (
   input  logic clk,
   input  logic rst,
   input  logic wr_trig,
   input  logic rd_trig,
   input  logic wr_clear,
   input  logic vga_done,
   output logic wrfifo_read_en,
   output logic rd_fifo_wr_en,
   output logic busy,
   output logic frame_wr_done,
   output logic burst_err,
   sdram_burst_sequencer_if.master sd
);

`ifdef FRAME_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   localparam int OW = AW - 1;
   localparam int BW = $clog2(BURST_LEN) + 2;
   localparam logic [OW-1:0] BL_STEP   = OW'(BURST_LEN);
   localparam logic [OW-1:0] FRAME_END = OW'(FRAME_WORDS);
   localparam logic [BW-1:0] BL_BEATS  = BW'(BURST_LEN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_BURST,
      ST_RD_REQ,
      ST_RD_BURST
   } state_t;

   state_t        state_q, state_d;
   logic          last_wr_q, last_wr_d;
   logic [OW-1:0] wr_off_q, wr_off_d;
   logic [OW-1:0] rd_off_q, rd_off_d;
   logic          wr_pend_q, wr_pend_d;
   logic          rd_pend_q, rd_pend_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [BW-1:0] beat_q, beat_d;
   logic          wr_req_q, wr_req_d;
   logic          rd_req_q, rd_req_d;
   logic          frame_q, frame_d;
   logic          err_q, err_d;

   logic          strobe;
   logic [BW-1:0] beat_nxt;
   logic [OW-1:0] wr_next, rd_next;
   logic          wr_side, rd_side;
   logic          wr_fin, rd_fin;

   // Data strobes pass straight through only inside the matching burst
   always_comb begin
      wrfifo_read_en = (state_q == ST_WR_BURST) && sd.sd_wr_data_req;
      rd_fifo_wr_en  = (state_q == ST_RD_BURST) && sd.sd_rd_data_vld;
      strobe         = wrfifo_read_en || rd_fifo_wr_en;
      beat_nxt       = (strobe && beat_q != '1) ? beat_q + BW'(1) : beat_q;
      wr_next        = wr_off_q + BL_STEP;
      rd_next        = rd_off_q + BL_STEP;
      wr_side        = (state_q == ST_WR_REQ) || (state_q == ST_WR_BURST);
      rd_side        = (state_q == ST_RD_REQ) || (state_q == ST_RD_BURST);
      wr_fin         = (state_q == ST_WR_BURST) && sd.sd_wr_done;
      rd_fin         = (state_q == ST_RD_BURST) && sd.sd_rd_done;
   end

   // Next-state, arbitration, beat counting and address bookkeeping
   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      wr_off_d  = wr_off_q;
      rd_off_d  = rd_off_q;
      wr_pend_d = wr_pend_q;
      rd_pend_d = rd_pend_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      beat_d    = beat_q;
      err_d     = err_q;
      frame_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (wr_trig && (!rd_trig || !last_wr_q)) begin
               state_d   = ST_WR_REQ;
               last_wr_d = 1'b1;
            end else if (rd_trig) begin
               state_d   = ST_RD_REQ;
               last_wr_d = 1'b0;
            end
         end
         ST_WR_REQ: begin
            if (sd.sd_wr_ack) begin
               state_d = ST_WR_BURST;
               beat_d  = '0;
            end
         end
         ST_WR_BURST: begin
            beat_d = beat_nxt;
            if (sd.sd_wr_done) begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_REQ: begin
            if (sd.sd_rd_ack) begin
               state_d = ST_RD_BURST;
               beat_d  = '0;
            end
         end
         ST_RD_BURST: begin
            beat_d = beat_nxt;
            if (sd.sd_rd_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if ((wr_fin || rd_fin) && beat_nxt != BL_BEATS) begin
         err_d = 1'b1;
      end

      // A clear seen during its own burst is deferred to the burst end
      if (wr_fin) begin
         wr_pend_d = 1'b0;
         if (wr_pend_q || wr_clear) begin
            wr_off_d = '0;
         end else if (wr_next == FRAME_END) begin
            wr_off_d  = '0;
            frame_d   = 1'b1;
            wr_bank_d = PP & ~wr_bank_q;
         end else begin
            wr_off_d = wr_next;
         end
      end else if (wr_clear) begin
         if (wr_side) begin
            wr_pend_d = 1'b1;
         end else begin
            wr_off_d = '0;
         end
      end

      // Reads restart on the newest complete frame bank
      if (rd_fin) begin
         rd_pend_d = 1'b0;
         if (rd_pend_q || vga_done || rd_next == FRAME_END) begin
            rd_off_d  = '0;
            rd_bank_d = PP & ~wr_bank_q;
         end else begin
            rd_off_d = rd_next;
         end
      end else if (vga_done) begin
         if (rd_side) begin
            rd_pend_d = 1'b1;
         end else begin
            rd_off_d  = '0;
            rd_bank_d = PP & ~wr_bank_q;
         end
      end

      wr_req_d = (state_d == ST_WR_REQ);
      rd_req_d = (state_d == ST_RD_REQ);
   end

   // State and bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         last_wr_q <= 1'b0;
         wr_off_q  <= '0;
         rd_off_q  <= '0;
         wr_pend_q <= 1'b0;
         rd_pend_q <= 1'b0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         beat_q    <= '0;
         wr_req_q  <= 1'b0;
         rd_req_q  <= 1'b0;
         frame_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         wr_off_q  <= wr_off_d;
         rd_off_q  <= rd_off_d;
         wr_pend_q <= wr_pend_d;
         rd_pend_q <= rd_pend_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         beat_q    <= beat_d;
         wr_req_q  <= wr_req_d;
         rd_req_q  <= rd_req_d;
         frame_q   <= frame_d;
         err_q     <= err_d;
      end
   end

   // Registered outputs to the core and status
   always_comb begin
      sd.sd_wr_req  = wr_req_q;
      sd.sd_wr_addr = {wr_bank_q, wr_off_q};
      sd.sd_rd_req  = rd_req_q;
      sd.sd_rd_addr = {rd_bank_q, rd_off_q};
      busy          = (state_q != ST_IDLE);
      frame_wr_done = frame_q;
      burst_err     = err_q;
   end

endmodule

// File: tb/tb_sdram_burst_sequencer.sv
// Directed bench for sdram_burst_sequencer with a scoreboard of
// expected burst op/address/frame-pulse triples.
module tb_sdram_burst_sequencer;

   localparam int AW = 22;
   localparam int BL = 256;
   localparam int FW = 2048;
`ifdef FRAME_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   typedef struct {
      bit            is_wr;
      logic [AW-1:0] addr;
      bit            frame;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic wr_trig, rd_trig, wr_clear, vga_done;
   logic wrfifo_read_en, rd_fifo_wr_en, busy;
   logic frame_wr_done, burst_err;

   int   errors = 0;
   int   checks = 0;
   exp_t sbq[$];

   int   m_woff, m_roff;
   bit   m_wbank, m_rbank;
   int   strobes;

   sdram_burst_sequencer_if #(.AW(AW)) sd ();

   sdram_burst_sequencer #(
      .AW(AW), .BURST_LEN(BL), .FRAME_WORDS(FW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wr_trig(wr_trig),
      .rd_trig(rd_trig),
      .wr_clear(wr_clear),
      .vga_done(vga_done),
      .wrfifo_read_en(wrfifo_read_en),
      .rd_fifo_wr_en(rd_fifo_wr_en),
      .busy(busy),
      .frame_wr_done(frame_wr_done),
      .burst_err(burst_err),
      .sd(sd)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   // Model of the write address: push expectation, then advance
   task automatic exp_wr(input bit clr);
      exp_t e;
      e.is_wr = 1'b1;
      e.addr  = AW'({m_wbank, 21'(m_woff)});
      e.frame = 1'b0;
      if (clr) begin
         m_woff = 0;
      end else if (m_woff + BL == FW) begin
         m_woff  = 0;
         e.frame = 1'b1;
         if (PP) m_wbank = ~m_wbank;
      end else begin
         m_woff = m_woff + BL;
      end
      sbq.push_back(e);
   endtask

   task automatic exp_rd();
      exp_t e;
      e.is_wr = 1'b0;
      e.addr  = AW'({m_rbank, 21'(m_roff)});
      e.frame = 1'b0;
      if (m_roff + BL == FW) begin
         m_roff = 0;
         if (PP) m_rbank = ~m_wbank;
      end else begin
         m_roff = m_roff + BL;
      end
      sbq.push_back(e);
   endtask

   // SDRAM core model: wait for a request, ack after 3 cycles, beats
   task automatic serve(input int nbeats, input int clr_beat,
                        output int nstb);
      int   t;
      bit   wr;
      exp_t e;
      nstb = 0;
      t = 0;
      while (!sd.sd_wr_req && !sd.sd_rd_req && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         chk("req_seen", {31'd0, sd.sd_wr_req | sd.sd_rd_req}, 1);
         return;
      end
      wr = sd.sd_wr_req;
      if (sbq.size() == 0) begin
         chk("sb_nonempty", sbq.size(), 1);
         return;
      end
      e = sbq.pop_front();
      chk("op", {31'd0, wr}, {31'd0, e.is_wr});
      chk("addr", wr ? sd.sd_wr_addr : sd.sd_rd_addr, e.addr);
      repeat (2) @(negedge clk);
      chk("req_held", wr ? sd.sd_wr_req : sd.sd_rd_req, 1);
      chk("addr_held", wr ? sd.sd_wr_addr : sd.sd_rd_addr, e.addr);
      if (wr) sd.sd_wr_ack = 1'b1;
      else    sd.sd_rd_ack = 1'b1;
      @(negedge clk);
      sd.sd_wr_ack = 1'b0;
      sd.sd_rd_ack = 1'b0;
      chk("req_drop", wr ? sd.sd_wr_req : sd.sd_rd_req, 0);
      for (int i = 0; i < nbeats; i++) begin
         if (wr) sd.sd_wr_data_req = 1'b1;
         else    sd.sd_rd_data_vld = 1'b1;
         if (i == clr_beat) begin
            if (wr) wr_clear = 1'b1;
            else    vga_done = 1'b1;
         end
         #1;
         if (wr ? wrfifo_read_en : rd_fifo_wr_en) nstb++;
         @(negedge clk);
         wr_clear = 1'b0;
         vga_done = 1'b0;
      end
      sd.sd_wr_data_req = 1'b0;
      sd.sd_rd_data_vld = 1'b0;
      if (wr) sd.sd_wr_done = 1'b1;
      else    sd.sd_rd_done = 1'b1;
      @(negedge clk);
      sd.sd_wr_done = 1'b0;
      sd.sd_rd_done = 1'b0;
      chk("gap_idle", busy, 0);
      chk("frame_pulse", frame_wr_done, e.frame);
   endtask

   initial begin
      int t;
      m_woff = 0; m_roff = 0; m_wbank = 0; m_rbank = 0;
      rst = 1'b1;
      wr_trig = 0; rd_trig = 0; wr_clear = 0; vga_done = 0;
      sd.sd_wr_ack = 0; sd.sd_wr_data_req = 0; sd.sd_wr_done = 0;
      sd.sd_rd_ack = 0; sd.sd_rd_data_vld = 0; sd.sd_rd_done = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_busy", busy, 0);
      chk("rst_wr_req", sd.sd_wr_req, 0);
      chk("rst_rd_req", sd.sd_rd_req, 0);
      chk("rst_err", burst_err, 0);
      chk("rst_frame", frame_wr_done, 0);
      sd.sd_wr_data_req = 1'b1;
      sd.sd_rd_data_vld = 1'b1;
      #1;
      chk("stray_wr_stb", wrfifo_read_en, 0);
      chk("stray_rd_stb", rd_fifo_wr_en, 0);
      @(negedge clk);
      sd.sd_wr_data_req = 1'b0;
      sd.sd_rd_data_vld = 1'b0;

      // single write trigger: two bursts at 0 and 256
      exp_wr(0);
      exp_wr(0);
      wr_trig = 1'b1;
      serve(BL, -1, strobes);
      chk("wr_strobes", strobes, BL);
      chk("wr_err", burst_err, 0);
      serve(BL, -1, strobes);
      wr_trig = 1'b0;

      // both triggers: strict alternation, last op was a write
      exp_rd();
      exp_wr(0);
      exp_rd();
      exp_wr(0);
      wr_trig = 1'b1;
      rd_trig = 1'b1;
      for (int k = 0; k < 4; k++) begin
         serve(BL, -1, strobes);
         chk("alt_strobes", strobes, BL);
      end
      wr_trig = 1'b0;
      rd_trig = 1'b0;

      // clear during a write burst restarts the next burst at 0
      exp_wr(1);
      wr_trig = 1'b1;
      serve(BL, 100, strobes);
      chk("clr_strobes", strobes, BL);

      // full frame of writes, then the wrapped burst
      for (int k = 0; k < FW / BL + 1; k++) exp_wr(0);
      for (int k = 0; k < FW / BL + 1; k++) serve(BL, -1, strobes);
      wr_trig = 1'b0;

      // vga_done in idle restarts reads on the complete bank
      @(negedge clk);
      vga_done = 1'b1;
      @(negedge clk);
      vga_done = 1'b0;
      m_roff = 0;
      if (PP) m_rbank = ~m_wbank;

      // short read burst raises a sticky error
      exp_rd();
      exp_rd();
      rd_trig = 1'b1;
      serve(BL - 1, -1, strobes);
      chk("short_strobes", strobes, BL - 1);
      chk("err_set", burst_err, 1);
      serve(BL, -1, strobes);
      rd_trig = 1'b0;
      chk("err_sticky", burst_err, 1);

      // reset in the middle of a read burst
      @(negedge clk);
      rd_trig = 1'b1;
      t = 0;
      while (!sd.sd_rd_req && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("mid_req", sd.sd_rd_req, 1);
      sd.sd_rd_ack = 1'b1;
      @(negedge clk);
      sd.sd_rd_ack = 1'b0;
      sd.sd_rd_data_vld = 1'b1;
      repeat (10) @(negedge clk);
      sd.sd_rd_data_vld = 1'b0;
      rst = 1'b1;
      rd_trig = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_req", sd.sd_rd_req, 0);
      chk("mid_rst_err", burst_err, 0);
      rst = 1'b0;
      m_woff = 0; m_roff = 0; m_wbank = 0; m_rbank = 0;
      @(negedge clk);

      // after reset writes begin again at address 0
      exp_wr(0);
      wr_trig = 1'b1;
      serve(BL, -1, strobes);
      wr_trig = 1'b0;
      chk("post_rst_err", burst_err, 0);
      chk("sb_drained", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
